// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch run/lap/clear sequencer: button conditioning, 4-state FSM, tick gating.
// Optional build macro STOPWATCH_AUTOSTOP_EN: pause on max_reached in RUN/LAP.

module stopwatch_run_ctrl_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   deb;
  logic [CW-1:0]          cnt;

  assign level = sync[SYNC_STAGES-1];

  // press is registered: it fires on the cycle the debounced level rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      deb   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      press <= 1'b0;
      if (level == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb   <= level;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module stopwatch_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       tick,
  input  logic       max_reached,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    LAP    = 2'b10,
    PAUSED = 2'b11
  } state_t;

  state_t cur;
  state_t nxt;
  logic   clr_nxt;
  logic   ss_press;
  logic   lc_press;
  logic   active;

  stopwatch_run_ctrl_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_ss (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_start_stop),
    .press(ss_press)
  );

  stopwatch_run_ctrl_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_lc (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_lap_clear),
    .press(lc_press)
  );

  assign active = (cur == RUN) || (cur == LAP);

`ifndef STOPWATCH_AUTOSTOP_EN
  logic unused_max;
  assign unused_max = max_reached;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      count_clr <= 1'b0;
    end else begin
      cur       <= nxt;
      count_clr <= clr_nxt;
    end
  end

  // start/stop has priority; a simultaneous lap/clear is dropped
  always_comb begin
    nxt     = cur;
    clr_nxt = 1'b0;
    unique case (cur)
      IDLE: begin
        if (ss_press) nxt = RUN;
      end
      RUN: begin
        if (ss_press)      nxt = PAUSED;
        else if (lc_press) nxt = LAP;
      end
      LAP: begin
        if (ss_press)      nxt = PAUSED;
        else if (lc_press) nxt = RUN;
      end
      PAUSED: begin
        if (ss_press) begin
          nxt = RUN;
        end else if (lc_press) begin
          nxt     = IDLE;
          clr_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
`ifdef STOPWATCH_AUTOSTOP_EN
    if (max_reached && active) nxt = PAUSED;
`endif
  end

  always_comb begin
    state    = cur;
    running  = active;
    lap_hold = (cur == LAP);
`ifdef STOPWATCH_AUTOSTOP_EN
    count_en = tick && active && !max_reached;
`else
    count_en = tick && active;
`endif
  end

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Scoreboard bench for stopwatch_run_ctrl with a press-timeline reference model.
// Honours STOPWATCH_AUTOSTOP_EN when the build defines it.

module tb_stopwatch_run_ctrl;

  localparam int D   = 4;
  localparam int S   = 2;
  localparam int LAT = S + D + 2;
`ifdef STOPWATCH_AUTOSTOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       bss  = 1'b0;
  logic       blc  = 1'b0;
  logic       tick = 1'b0;
  logic       maxr = 1'b0;
  logic       en;
  logic       clr;
  logic       lap;
  logic       run;
  logic [1:0] st;

  always #5 clk = ~clk;

  stopwatch_run_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_start_stop(bss),
    .btn_lap_clear (blc),
    .tick          (tick),
    .max_reached   (maxr),
    .count_en      (en),
    .count_clr     (clr),
    .lap_hold      (lap),
    .running       (run),
    .state         (st)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       lap;
    logic       run;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // model: state 0 idle, 1 run, 2 lap, 3 paused
  int   m_st = 0;
  bit   m_clr = 1'b0;
  bit   rst_cur = 1'b0;
  bit   max_cur = 1'b0;
  bit   ss_ev[int];
  bit   lc_ev[int];
  int   ss_nx[4] = '{1, 3, 3, 1};
  int   lc_nx[4] = '{0, 2, 1, 0};

  task automatic step(input bit s, input bit l, input bit r);
    bit   act;
    bit   pss;
    bit   plc;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    pss = ss_ev.exists(cyc);
    plc = lc_ev.exists(cyc);
    if (!rst_cur) begin
      m_st  = 0;
      m_clr = 1'b0;
    end else begin
      act   = (m_st == 1) || (m_st == 2);
      m_clr = 1'b0;
      if (AUTO && act && max_cur) begin
        m_st = 3;
      end else if (pss) begin
        m_st = ss_nx[m_st];
      end else if (plc) begin
        m_clr = (m_st == 3);
        m_st  = lc_nx[m_st];
      end
    end
    tick = ($urandom_range(2) == 0);
    maxr = ($urandom_range(11) == 0);
    bss  = s;
    blc  = l;
    rst  = r;
    if (!r) begin
      m_st  = 0;
      m_clr = 1'b0;
      ss_ev.delete();
      lc_ev.delete();
    end
    if (rst_cur && !r) begin
      #1;
      n_chk++;
      if ({st, en, clr, lap, run} != 6'd0) begin
        n_fail++;
        $display("FAIL async_reset cyc=%0d got st=%b en=%b clr=%b lap=%b run=%b want all 0",
                 cyc, st, en, clr, lap, run);
      end
    end
    rst_cur = r;
    max_cur = maxr;
    act     = (m_st == 1) || (m_st == 2);
    e.st    = m_st[1:0];
    e.en    = tick && act && !(AUTO && maxr);
    e.clr   = m_clr;
    e.lap   = (m_st == 2);
    e.run   = act;
    q.push_back(e);
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic press(input bit s, input bit l);
    step(s, l, 1'b1);
    if (s) ss_ev[cyc + LAT] = 1'b1;
    if (l) lc_ev[cyc + LAT] = 1'b1;
    repeat (D + $urandom_range(4)) step(s, l, 1'b1);
    gap(14 + $urandom_range(6));
  endtask

  task automatic glitch(input bit s);
    repeat ($urandom_range(D, 1)) step(s, !s, 1'b1);
    gap(12 + $urandom_range(4));
  endtask

  task automatic reset_drop();
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    gap(14);
  endtask

  task automatic reset_hold();
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    ss_ev[cyc + LAT] = 1'b1;
    repeat (D + 2) step(1'b1, 1'b0, 1'b1);
    gap(16);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ({st, en, clr, lap, run} != e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got st=%b en=%b clr=%b lap=%b run=%b want st=%b en=%b clr=%b lap=%b run=%b",
                 $time, st, en, clr, lap, run, e.st, e.en, e.clr, e.lap, e.run);
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    gap(4);
    press(1'b1, 1'b0);
    gap(20);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    gap(30);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    reset_drop();
    glitch(1'b1);
    glitch(1'b0);
    reset_hold();
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(6))
        0, 1:    press(1'b1, 1'b0);
        2, 3:    press(1'b0, 1'b1);
        4:       press(1'b1, 1'b1);
        5:       glitch($urandom_range(1) == 1);
        default: begin
          if ($urandom_range(3) == 0) reset_hold();
          else if ($urandom_range(3) == 0) reset_drop();
          else gap($urandom_range(30, 5));
        end
      endcase
    end
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
